// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: control from decode, instruction memory port and the IF/ID
// register outputs presented to decode.
interface instr_fetch_if;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_valid;
    logic        active;
    logic        fetch_error;

    modport master (
        input  stall, redirect_valid, redirect_target, instr,
        output pc, id_instr, id_pc, id_valid, active, fetch_error
    );

    modport slave (
        output stall, redirect_valid, redirect_target, instr,
        input  pc, id_instr, id_pc, id_valid, active, fetch_error
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage with one-word branch delay slot, stall-time redirect
// buffering, and halt on fetch address 0 or a misaligned fetch address.
module instr_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic           clk,
    input  logic           reset,
    instr_fetch_if.master  bus
);
    localparam int DATA_W = 32;

    typedef enum logic {RUN, HALTED} state_t;

    state_t              state, state_nx;
    logic [DATA_W-1:0]   pc_p0, pc_nx;
    logic                pend_p0, pend_nx;
    logic [DATA_W-1:0]   pend_tgt_p0, pend_tgt_nx;
    logic [DATA_W-1:0]   id_instr_p1, id_instr_nx;
    logic [DATA_W-1:0]   id_pc_p1, id_pc_nx;
    logic                vld_p1, vld_nx;
    logic                err, err_nx;
    logic [DATA_W-1:0]   next_pc;

    // A live redirect beats a buffered one, which beats sequential fetch.
    function automatic logic [DATA_W-1:0] select_next_pc(
        input logic              redir,
        input logic [DATA_W-1:0] redir_tgt,
        input logic              pend,
        input logic [DATA_W-1:0] pend_tgt,
        input logic [DATA_W-1:0] cur_pc
    );
        if (redir)
            return redir_tgt;
        else if (pend)
            return pend_tgt;
        else
            return cur_pc + 32'd4;
    endfunction

    assign next_pc = select_next_pc(bus.redirect_valid, bus.redirect_target,
                                    pend_p0, pend_tgt_p0, pc_p0);

    always_comb begin
        state_nx    = state;
        pc_nx       = pc_p0;
        pend_nx     = pend_p0;
        pend_tgt_nx = pend_tgt_p0;
        id_instr_nx = id_instr_p1;
        id_pc_nx    = id_pc_p1;
        vld_nx      = vld_p1;
        err_nx      = err;

        if (state == RUN) begin
            if (bus.stall) begin
                if (bus.redirect_valid) begin
                    pend_nx     = 1'b1;
                    pend_tgt_nx = bus.redirect_target;
                end
            end else begin
                pend_nx = 1'b0;
                pc_nx   = next_pc;
                // Halting edges keep the old IF/ID contents but drop valid,
                // so the delay-slot word never reaches decode in that case.
                if (next_pc == '0 || next_pc[1:0] != 2'b00) begin
                    state_nx = HALTED;
                    vld_nx   = 1'b0;
                    if (next_pc[1:0] != 2'b00)
                        err_nx = 1'b1;
                end else begin
                    id_instr_nx = bus.instr;
                    id_pc_nx    = pc_p0;
                    vld_nx      = 1'b1;
                end
            end
        end
    end

    // ---- fetch (p0) / IF-ID (p1) register boundary ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            pc_p0       <= RESET_VECTOR;
            pend_p0     <= 1'b0;
            pend_tgt_p0 <= '0;
            id_instr_p1 <= '0;
            id_pc_p1    <= '0;
            vld_p1      <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_nx;
            pc_p0       <= pc_nx;
            pend_p0     <= pend_nx;
            pend_tgt_p0 <= pend_tgt_nx;
            id_instr_p1 <= id_instr_nx;
            id_pc_p1    <= id_pc_nx;
            vld_p1      <= vld_nx;
            err         <= err_nx;
        end
    end

    assign bus.pc          = pc_p0;
    assign bus.id_instr    = id_instr_p1;
    assign bus.id_pc       = id_pc_p1;
    assign bus.id_valid    = vld_p1;
    assign bus.active      = (state == RUN);
    assign bus.fetch_error = err;
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_VECTOR, default 32'hBFC00000, meaning the address of the first fetch after reset.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 stall  input  1  downstream hold request; freezes PC and IF/ID register.
REQ-005 redirect_valid  input  1  taken branch/jump resolved in ID this cycle.
REQ-006 redirect_target  input  32  byte address of the redirect destination.
REQ-007 pc  output  32  current fetch address, driven to instruction memory.
REQ-008 instr  input  32  word read asynchronously from instruction memory at pc, valid in the same cycle.
REQ-009 id_instr  output  32  registered instruction presented to decode.
REQ-010 id_pc  output  32  registered address of id_instr.
REQ-011 id_valid  output  1  id_instr/id_pc hold a real instruction; 0 = bubble.
REQ-012 active  output  1  CPU running; 0 = halted.
REQ-013 fetch_error  output  1  sticky; misaligned fetch address was loaded.

Function
REQ-014 Two states: RUN and HALTED; active SHALL be 1 exactly when state is RUN.
REQ-015 Internal pending-redirect flag plus 32-bit pending target.
REQ-016 RUN, stall=0: id_instr<=instr, id_pc<=pc, id_valid<=1, pc<=next_pc, pending cleared.
REQ-017 next_pc priority: redirect_target if redirect_valid; else pending target if pending set; else pc+4 (32-bit, wraps modulo 2^32).
REQ-018 Branch delay slot: redirect does not cancel the word fetched in the redirect cycle; that word enters ID normally, target is fetched the following cycle (zero bubbles).
REQ-019 RUN, stall=1: pc, id_instr, id_pc, id_valid hold; if redirect_valid, pending<=1 and pending target<=redirect_target (later redirect overwrites earlier).
REQ-020 Halt: in RUN with stall=0, if next_pc==0, state<=HALTED and pc<=0 on the same edge; active SHALL read 0 in the cycle pc first reads 0; the word at address 0 never enters ID.
REQ-021 pc+4 wrap from 32'hFFFFFFFC to 0 SHALL halt per REQ-020.
REQ-022 Misalignment: in RUN with stall=0, if next_pc[1:0]!=0, pc<=next_pc, state<=HALTED, fetch_error<=1 on the same edge.
REQ-023 On any transition into HALTED, id_valid<=0 on the same edge (id_instr, id_pc hold).
REQ-024 HALTED: pc, id_instr, id_pc hold; id_valid=0; stall, redirect_valid, redirect_target ignored; leave only via reset.
REQ-025 fetch_error, once set, SHALL remain 1 until reset.
REQ-026 Single-cycle latency: instruction at pc appears on id_instr one edge later when not stalled.

Reset
REQ-027 reset=1 at a rising edge SHALL set pc=RESET_VECTOR, id_instr=0, id_pc=0, id_valid=0, pending=0, fetch_error=0, state=RUN (active=1), overriding stall and redirect.
REQ-028 Reset asserted mid-operation (stalled, pending redirect, or HALTED) SHALL produce identical state to REQ-027.
REQ-029 Reset SHALL not depend on memory contents; instr is ignored while reset=1.

Verification
REQ-030 Reset then 3 free-running cycles, memory returns addr as data -> pc=BFC0000C, id_pc=BFC00008, id_instr=BFC00008, id_valid=1, active=1.
REQ-031 redirect_valid=1 target BFC00100 while pc=BFC00004 -> next edge id_pc=BFC00004 (delay slot), pc=BFC00100; following edge id_pc=BFC00100.
REQ-032 stall=1 for 2 cycles with redirect to BFC00200 in first stalled cycle only -> pc/id_* frozen both cycles; first unstalled edge pc=BFC00200.
REQ-033 Redirect to 0 -> same edge pc=0, active=0, id_valid=0; later redirect to BFC00000 ignored, pc stays 0.
REQ-034 Redirect to BFC00102 -> pc=BFC00102, fetch_error=1, active=0; stays set with stall toggling.
REQ-035 Reset asserted for one cycle while HALTED with fetch_error=1 -> pc=BFC00000, active=1, fetch_error=0, id_valid=0.
